// File: rtl/game_round_sequencer.sv
// ---------------------------------------------------------------------------
// game_round_sequencer
//
// Sequences rounds of the hMove/cMove game FSM. Human moves arrive over a
// valid/ready handshake and are forwarded to the game FSM as one-cycle hMove
// pulses, one per round. Each round's win/cMove is sampled, a move limit and
// an idle timeout are enforced, and saturating human/CPU scores are kept.
//
// Every output is a register. There is no combinational path from any input
// to any output.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        level; begins a new game from IDLE/DONE, aborts from WAIT_MOVE
//   i_move_valid   i_move_in is valid this cycle
//   i_move_in      human move; legal range 0..9
//   o_move_ready   sequencer accepts i_move_in this cycle
//   i_cmove        computer move from the game FSM
//   i_win          win flag from the game FSM
//   o_hmove        move to the game FSM; 4'hF = no move
//   o_fsm_reset    active-high reset to the game FSM
//   o_last_cmove   i_cmove captured in the most recent CHECK
//   o_human_score  games won by the human (saturating)
//   o_cpu_score    games won by the CPU via move limit or timeout (saturating)
//   o_game_over    1 while in DONE
//   o_human_won    result of the last finished game
//   o_busy         1 in CLR, WAIT_MOVE, APPLY, CHECK
//
// State table
//   state       | meaning
//   S_IDLE      | game FSM held in reset, waiting for start
//   S_CLR       | game FSM reset for 2 cycles, round counters cleared
//   S_WAIT_MOVE | ready for a human move, idle timeout running
//   S_APPLY     | latched move driven on hMove for one cycle
//   S_CHECK     | sample win/cMove, decide end of game
//   S_DONE      | game finished, FSM holds its final state
// ---------------------------------------------------------------------------
module game_round_sequencer #(
  parameter int MAX_MOVES   = 8,
  parameter int TIMEOUT_CYC = 16,
  parameter int SCORE_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_move_valid,
  input  logic [3:0]         i_move_in,
  output logic               o_move_ready,
  input  logic [3:0]         i_cmove,
  input  logic               i_win,
  output logic [3:0]         o_hmove,
  output logic               o_fsm_reset,
  output logic [3:0]         o_last_cmove,
  output logic [SCORE_W-1:0] o_human_score,
  output logic [SCORE_W-1:0] o_cpu_score,
  output logic               o_game_over,
  output logic               o_human_won,
  output logic               o_busy
);

  localparam int MC_W = $clog2(MAX_MOVES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0]         NO_MOVE   = 4'hF;
  localparam logic [3:0]         MOVE_MAX  = 4'd9;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [MC_W-1:0]    MC_LIMIT  = MC_W'(MAX_MOVES);
  // Down-counter load: reaching zero marks the TIMEOUT_CYC-th idle cycle.
  localparam logic [TO_W-1:0]    TO_LOAD   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR       = 3'd1,
    S_WAIT_MOVE = 3'd2,
    S_APPLY     = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_clr_cnt;
  logic [MC_W-1:0]    r_move_cnt;
  logic [TO_W-1:0]    r_tmo_cnt;
  logic [3:0]         r_hmove;
  logic               r_fsm_reset;
  logic               r_move_ready;
  logic [3:0]         r_last_cmove;
  logic [SCORE_W-1:0] r_human_score;
  logic [SCORE_W-1:0] r_cpu_score;
  logic               r_game_over;
  logic               r_human_won;
  logic               r_busy;

  logic w_move_legal;
  logic w_human_sat;
  logic w_cpu_sat;
  logic w_tmo_done;
  logic w_limit_hit;

  assign w_move_legal = (i_move_in <= MOVE_MAX);
  assign w_human_sat  = (r_human_score == SCORE_MAX);
  assign w_cpu_sat    = (r_cpu_score == SCORE_MAX);
  assign w_tmo_done   = (r_tmo_cnt == '0);
  assign w_limit_hit  = (r_move_cnt == MC_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_clr_cnt     <= 1'b0;
      r_move_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_hmove       <= NO_MOVE;
      r_fsm_reset   <= 1'b1;
      r_move_ready  <= 1'b0;
      r_last_cmove  <= 4'd0;
      r_human_score <= '0;
      r_cpu_score   <= '0;
      r_game_over   <= 1'b0;
      r_human_won   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_CLR;
            r_clr_cnt    <= 1'b0;
            r_move_cnt   <= '0;
            r_tmo_cnt    <= TO_LOAD;
            r_fsm_reset  <= 1'b1;
            r_move_ready <= 1'b0;
            r_game_over  <= 1'b0;
            r_busy       <= 1'b1;
            r_hmove      <= NO_MOVE;
          end
        end

        S_CLR: begin
          // r_clr_cnt distinguishes the first and second CLR cycle.
          if (r_clr_cnt) begin
            r_state      <= S_WAIT_MOVE;
            r_fsm_reset  <= 1'b0;
            r_move_ready <= 1'b1;
          end else begin
            r_clr_cnt <= 1'b1;
          end
        end

        S_WAIT_MOVE: begin
          if (i_start) begin
            // Abort: the move offered this cycle (if any) is dropped.
            r_state      <= S_CLR;
            r_clr_cnt    <= 1'b0;
            r_move_cnt   <= '0;
            r_tmo_cnt    <= TO_LOAD;
            r_fsm_reset  <= 1'b1;
            r_move_ready <= 1'b0;
            r_game_over  <= 1'b0;
            r_busy       <= 1'b1;
            r_hmove      <= NO_MOVE;
          end else if (i_move_valid && w_move_legal) begin
            r_state      <= S_APPLY;
            r_hmove      <= i_move_in;
            r_move_ready <= 1'b0;
            r_tmo_cnt    <= TO_LOAD;
          end else if (w_tmo_done) begin
            // Idle (or illegal-only) cycles exhausted: human forfeits.
            r_state      <= S_DONE;
            r_move_ready <= 1'b0;
            r_game_over  <= 1'b1;
            r_human_won  <= 1'b0;
            r_busy       <= 1'b0;
            if (!w_cpu_sat) begin
              r_cpu_score <= r_cpu_score + SCORE_W'(1);
            end
          end else begin
            // Illegal moves are consumed here too and do not stop the timer.
            r_tmo_cnt <= r_tmo_cnt - TO_W'(1);
          end
        end

        S_APPLY: begin
          r_state    <= S_CHECK;
          r_hmove    <= NO_MOVE;
          r_move_cnt <= r_move_cnt + MC_W'(1);
        end

        S_CHECK: begin
          r_last_cmove <= i_cmove;
          if (i_win) begin
            r_state     <= S_DONE;
            r_game_over <= 1'b1;
            r_human_won <= 1'b1;
            r_busy      <= 1'b0;
            if (!w_human_sat) begin
              r_human_score <= r_human_score + SCORE_W'(1);
            end
          end else if (w_limit_hit) begin
            r_state     <= S_DONE;
            r_game_over <= 1'b1;
            r_human_won <= 1'b0;
            r_busy      <= 1'b0;
            if (!w_cpu_sat) begin
              r_cpu_score <= r_cpu_score + SCORE_W'(1);
            end
          end else begin
            r_state      <= S_WAIT_MOVE;
            r_move_ready <= 1'b1;
          end
        end

        S_DONE: begin
          if (i_start) begin
            r_state      <= S_CLR;
            r_clr_cnt    <= 1'b0;
            r_move_cnt   <= '0;
            r_tmo_cnt    <= TO_LOAD;
            r_fsm_reset  <= 1'b1;
            r_move_ready <= 1'b0;
            r_game_over  <= 1'b0;
            r_busy       <= 1'b1;
            r_hmove      <= NO_MOVE;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_fsm_reset  <= 1'b1;
          r_move_ready <= 1'b0;
          r_hmove      <= NO_MOVE;
          r_game_over  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_move_ready  = r_move_ready;
  assign o_hmove       = r_hmove;
  assign o_fsm_reset   = r_fsm_reset;
  assign o_last_cmove  = r_last_cmove;
  assign o_human_score = r_human_score;
  assign o_cpu_score   = r_cpu_score;
  assign o_game_over   = r_game_over;
  assign o_human_won   = r_human_won;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_game_round_sequencer.sv
module tb_game_round_sequencer;

  localparam int MAX_MOVES = 8;
  localparam int SCORE_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_move_valid = 1'b0;
  logic [3:0] i_move_in = 4'h0;
  logic       o_move_ready;
  logic [3:0] o_hmove;
  logic       o_fsm_reset;
  logic [3:0] o_last_cmove;
  logic [3:0] o_human_score;
  logic [3:0] o_cpu_score;
  logic       o_game_over;
  logic       o_human_won;
  logic       o_busy;

  // Game FSM model (environment): registers cMove and win from each hMove.
  logic [3:0] fsm_cmove;
  logic       fsm_win;
  logic [3:0] key_r = 4'd10;

  always #5 clk = ~clk;

  game_round_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_move_valid  (i_move_valid),
    .i_move_in     (i_move_in),
    .o_move_ready  (o_move_ready),
    .i_cmove       (fsm_cmove),
    .i_win         (fsm_win),
    .o_hmove       (o_hmove),
    .o_fsm_reset   (o_fsm_reset),
    .o_last_cmove  (o_last_cmove),
    .o_human_score (o_human_score),
    .o_cpu_score   (o_cpu_score),
    .o_game_over   (o_game_over),
    .o_human_won   (o_human_won),
    .o_busy        (o_busy)
  );

  function automatic logic [3:0] cmodel(input logic [3:0] m);
    return 4'((int'(m) * 7 + 3) % 10);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_cmove <= 4'd0;
      fsm_win   <= 1'b0;
    end else if (o_fsm_reset) begin
      fsm_cmove <= 4'd0;
      fsm_win   <= 1'b0;
    end else if (o_hmove != 4'hF) begin
      fsm_cmove <= cmodel(o_hmove);
      fsm_win   <= (o_hmove == key_r);
    end
  end

  // Scoreboard
  typedef struct {
    bit   is_done;
    int   hmove;
    int   won;
    int   hs;
    int   cs;
    int   last;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_h = 0;
  int   exp_c = 0;
  int   exp_last = 0;
  logic [3:0] g_mv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 1;
  endfunction

  task automatic push_hmove(input logic [3:0] m);
    exp_t e;
    e.is_done = 1'b0; e.hmove = int'(m); e.won = 0; e.hs = 0; e.cs = 0; e.last = 0;
    sb_q.push_back(e);
  endtask

  task automatic push_done(input int won);
    exp_t e;
    e.is_done = 1'b1; e.hmove = 15; e.won = won; e.hs = exp_h; e.cs = exp_c; e.last = exp_last;
    sb_q.push_back(e);
  endtask

  // Monitor: pops an expectation for every hMove pulse and every game end.
  exp_t mon_e;
  logic prev_go = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_go = 1'b0;
    end else begin
      if (o_hmove != 4'hF) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_hmove", 32'(o_hmove), 32'hF);
        end else begin
          mon_e = sb_q.pop_front();
          chk("event_kind_hmove", 32'(mon_e.is_done), 32'd0);
          chk("hmove", 32'(o_hmove), 32'(mon_e.hmove));
        end
      end
      if (o_game_over && !prev_go) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_game_over", 32'(o_game_over), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("event_kind_done", 32'(mon_e.is_done), 32'd1);
          chk("human_won", 32'(o_human_won), 32'(mon_e.won));
          chk("human_score", 32'(o_human_score), 32'(mon_e.hs));
          chk("cpu_score", 32'(o_cpu_score), 32'(mon_e.cs));
          chk("last_cmove", 32'(o_last_cmove), 32'(mon_e.last));
          chk("busy_in_done", 32'(o_busy), 32'd0);
          chk("fsm_reset_in_done", 32'(o_fsm_reset), 32'd0);
        end
      end
      prev_go = o_game_over;
    end
  end

  // All driver tasks are entered and left just after a falling edge.
  task automatic start_game(input logic [3:0] key);
    key_r   = key;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] m, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    while (!o_move_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("move_ready", 32'(o_move_ready), 32'd1);
    i_move_valid = 1'b1;
    i_move_in    = m;
    @(posedge clk);
    if (m <= 4'd9) push_hmove(m);
    #1;
    i_move_valid = 1'b0;
    i_move_in    = 4'h0;
    @(negedge clk);
  endtask

  // Bench-level outcome of a legal move: ends the game on win or move limit.
  task automatic account(input logic [3:0] m, input int cnt, output bit ended);
    ended    = 1'b0;
    exp_last = int'(cmodel(m));
    if (m == key_r) begin
      exp_h = sat(exp_h);
      push_done(1);
      ended = 1'b1;
    end else if (cnt == MAX_MOVES) begin
      exp_c = sat(exp_c);
      push_done(0);
      ended = 1'b1;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!o_game_over && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("game_over_reached", 32'(o_game_over), 32'd1);
  endtask

  task automatic play_game(input int n, input logic [3:0] key);
    int cnt = 0;
    bit ended = 1'b0;
    start_game(key);
    for (int i = 0; i < n && !ended; i++) begin
      send(g_mv[i], $urandom_range(0, 3));
      if (g_mv[i] <= 4'd9) begin
        cnt++;
        account(g_mv[i], cnt, ended);
      end
    end
    if (!ended) begin
      exp_c = sat(exp_c);
      push_done(0);
    end
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ended;
    int k;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_fsm_reset", 32'(o_fsm_reset), 32'd1);
    chk("rst_hmove", 32'(o_hmove), 32'hF);
    chk("rst_move_ready", 32'(o_move_ready), 32'd0);
    chk("rst_game_over", 32'(o_game_over), 32'd0);
    chk("rst_human_won", 32'(o_human_won), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_last_cmove", 32'(o_last_cmove), 32'd0);
    chk("rst_human_score", 32'(o_human_score), 32'd0);
    chk("rst_cpu_score", 32'(o_cpu_score), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_fsm_reset", 32'(o_fsm_reset), 32'd1);

    // 2: moves 6,9,2 with win on the third
    g_mv[0] = 4'd6; g_mv[1] = 4'd9; g_mv[2] = 4'd2;
    play_game(3, 4'd2);
    chk("t2_human_score", 32'(o_human_score), 32'd1);
    chk("t2_human_won", 32'(o_human_won), 32'd1);

    // 3: illegal move consumed, then timeout after 16 WAIT_MOVE cycles
    start_game(4'd10);
    send(4'hC, 0);
    exp_c = sat(exp_c);
    push_done(0);
    k = 1;
    while (!o_game_over && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd16);
    chk("t3_cpu_score", 32'(o_cpu_score), 32'd1);

    // 4: move limit without a win
    for (int i = 0; i < 8; i++) g_mv[i] = 4'($urandom_range(0, 9));
    play_game(8, 4'd10);

    // 5: start and move together in WAIT_MOVE abort to CLR
    start_game(4'd3);
    k = 0;
    while (!o_move_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    i_start = 1'b1; i_move_valid = 1'b1; i_move_in = 4'd5;
    @(posedge clk);
    #1 i_start = 1'b0; i_move_valid = 1'b0; i_move_in = 4'h0;
    @(negedge clk);
    chk("abort_clr1_fsm_reset", 32'(o_fsm_reset), 32'd1);
    chk("abort_clr1_busy", 32'(o_busy), 32'd1);
    chk("abort_clr1_ready", 32'(o_move_ready), 32'd0);
    @(negedge clk);
    chk("abort_clr2_fsm_reset", 32'(o_fsm_reset), 32'd1);
    @(negedge clk);
    chk("abort_wait_fsm_reset", 32'(o_fsm_reset), 32'd0);
    chk("abort_wait_ready", 32'(o_move_ready), 32'd1);
    send(4'd3, 0);
    account(4'd3, 1, ended);
    wait_done();

    // win on the 8th move beats the move limit
    for (int i = 0; i < 8; i++) g_mv[i] = 4'(i);
    play_game(8, 4'd7);

    // randomized games, never two illegal moves in a row
    for (int gidx = 0; gidx < 14; gidx++) begin
      bit prev_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (!prev_bad && $urandom_range(0, 6) == 0) begin
          g_mv[i] = 4'($urandom_range(10, 15));
          prev_bad = 1'b1;
        end else begin
          g_mv[i] = 4'($urandom_range(0, 9));
          prev_bad = 1'b0;
        end
      end
      play_game(10, 4'($urandom_range(0, 10)));
    end

    // 6: human score saturates
    while (exp_h < SCORE_MAX) begin
      g_mv[0] = 4'($urandom_range(0, 9));
      play_game(1, g_mv[0]);
    end
    g_mv[0] = 4'd4;
    play_game(1, 4'd4);
    chk("human_score_saturated", 32'(o_human_score), 32'd15);

    // reset dropped during APPLY
    start_game(4'd10);
    k = 0;
    while (!o_move_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    i_move_valid = 1'b1; i_move_in = 4'd8;
    @(posedge clk);
    #1 i_move_valid = 1'b0;
    chk("apply_hmove_before_reset", 32'(o_hmove), 32'd8);
    rst_n = 1'b0;
    sb_q.delete();
    exp_h = 0; exp_c = 0; exp_last = 0;
    #1;
    chk("midreset_hmove", 32'(o_hmove), 32'hF);
    chk("midreset_fsm_reset", 32'(o_fsm_reset), 32'd1);
    chk("midreset_human_score", 32'(o_human_score), 32'd0);
    chk("midreset_cpu_score", 32'(o_cpu_score), 32'd0);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_ready", 32'(o_move_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    g_mv[0] = 4'd1; g_mv[1] = 4'd5;
    play_game(2, 4'd5);
    chk("post_reset_human_score", 32'(o_human_score), 32'd1);

    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
